control_pipe: RTL and testbench

- Carries the 4-bit control bundle {ALUOp[1:0], WBSig, MEMSig} from the ID-stage control mux through the ID/EX, EX/MEM and MEM/WB pipeline registers.
- Each stage drops the fields it consumes: ALUOp in EX, MEMSig in MEM, WBSig in WB.
- Inserts bubbles on hazard stall and branch flush, and freezes all stages on a memory wait.
- Keeps a saturating count of the bubbles it inserts, for performance debug.

---
 rtl/control_pipe_if.sv | 38 +++
 rtl/control_pipe.sv | 126 ++++++++++++
 tb/tb_control_pipe.sv | 251 +++++++++++++++++++++++++
 3 files changed

// File: rtl/control_pipe_if.sv
// Control-bundle pipeline bus: ID-side inputs, hazard controls and the
// per-stage outputs of control_pipe, grouped so one handle carries them all.
interface control_pipe_if #(
    parameter int RD_W  = 5,
    parameter int CNT_W = 16
);
    logic [3:0]      controlSig;
    logic            id_valid;
    logic [RD_W-1:0] id_rd;
    logic            stall;
    logic            flush;
    logic            mem_wait;

    logic [1:0]       ex_ALUOp;
    logic             ex_valid;
    logic [RD_W-1:0]  ex_rd;
    logic             mem_MEMSig;
    logic             mem_valid;
    logic [RD_W-1:0]  mem_rd;
    logic             wb_regwrite;
    logic             wb_valid;
    logic [RD_W-1:0]  wb_rd;
    logic [CNT_W-1:0] bubble_count;

    // ID stage / hazard unit side
    modport master (
        output controlSig, id_valid, id_rd, stall, flush, mem_wait,
        input  ex_ALUOp, ex_valid, ex_rd, mem_MEMSig, mem_valid, mem_rd,
               wb_regwrite, wb_valid, wb_rd, bubble_count
    );

    // Pipeline register side
    modport slave (
        input  controlSig, id_valid, id_rd, stall, flush, mem_wait,
        output ex_ALUOp, ex_valid, ex_rd, mem_MEMSig, mem_valid, mem_rd,
               wb_regwrite, wb_valid, wb_rd, bubble_count
    );
endinterface

// File: rtl/control_pipe.sv
// Carries {ALUOp, WBSig, MEMSig} through ID/EX, EX/MEM and MEM/WB, dropping
// each field once its stage has consumed it. Stall and flush insert bubbles,
// mem_wait freezes everything, and inserted bubbles are counted (saturating).
module control_pipe #(
    parameter int RD_W  = 5,
    parameter int CNT_W = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    control_pipe_if.slave pipe
);

    localparam logic [CNT_W:0] CNT_MAX = {1'b0, {CNT_W{1'b1}}};

    // ID/EX
    logic [1:0]      ex_aluop_q;
    logic            ex_wb_q;
    logic            ex_mem_q;
    logic            ex_valid_q;
    logic [RD_W-1:0] ex_rd_q;
    // EX/MEM
    logic            mem_wb_q;
    logic            mem_mem_q;
    logic            mem_valid_q;
    logic [RD_W-1:0] mem_rd_q;
    // MEM/WB
    logic            wb_wb_q;
    logic            wb_valid_q;
    logic [RD_W-1:0] wb_rd_q;

    logic [CNT_W-1:0] bubble_cnt_q;
    logic [CNT_W-1:0] bubble_cnt_d;
    logic [1:0]       bubble_inc;
    logic [CNT_W:0]   bubble_sum;
    logic             id_take_bubble;

    // ID/EX gets a bubble on stall, flush, or when ID has no real instruction
    assign id_take_bubble = pipe.stall | pipe.flush | ~pipe.id_valid;

    // Bubbles inserted this edge (flush dominates stall), clamped at the maximum
    always_comb begin
        bubble_inc = 2'd0;
        if (!pipe.mem_wait) begin
            if (pipe.flush) begin
                bubble_inc = 2'd2;
            end else if (pipe.stall) begin
                bubble_inc = 2'd1;
            end
        end
        bubble_sum = {1'b0, bubble_cnt_q} + (CNT_W + 1)'(bubble_inc);
        if (bubble_sum > CNT_MAX) begin
            bubble_cnt_d = CNT_MAX[CNT_W-1:0];
        end else begin
            bubble_cnt_d = bubble_sum[CNT_W-1:0];
        end
    end

    // Stage registers: hold on mem_wait, otherwise advance with bubble insertion
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_aluop_q  <= '0;
            ex_wb_q     <= 1'b0;
            ex_mem_q    <= 1'b0;
            ex_valid_q  <= 1'b0;
            ex_rd_q     <= '0;
            mem_wb_q    <= 1'b0;
            mem_mem_q   <= 1'b0;
            mem_valid_q <= 1'b0;
            mem_rd_q    <= '0;
            wb_wb_q     <= 1'b0;
            wb_valid_q  <= 1'b0;
            wb_rd_q     <= '0;
        end else if (!pipe.mem_wait) begin
            wb_wb_q    <= mem_wb_q;
            wb_valid_q <= mem_valid_q;
            wb_rd_q    <= mem_rd_q;

            if (pipe.flush) begin
                mem_wb_q    <= 1'b0;
                mem_mem_q   <= 1'b0;
                mem_valid_q <= 1'b0;
                mem_rd_q    <= '0;
            end else begin
                mem_wb_q    <= ex_wb_q;
                mem_mem_q   <= ex_mem_q;
                mem_valid_q <= ex_valid_q;
                mem_rd_q    <= ex_rd_q;
            end

            if (id_take_bubble) begin
                ex_aluop_q <= '0;
                ex_wb_q    <= 1'b0;
                ex_mem_q   <= 1'b0;
                ex_valid_q <= 1'b0;
                ex_rd_q    <= '0;
            end else begin
                ex_aluop_q <= pipe.controlSig[3:2];
                ex_wb_q    <= pipe.controlSig[1];
                ex_mem_q   <= pipe.controlSig[0];
                ex_valid_q <= 1'b1;
                ex_rd_q    <= pipe.id_rd;
            end
        end
    end

    // Bubble counter, frozen during mem_wait
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bubble_cnt_q <= '0;
        end else if (!pipe.mem_wait) begin
            bubble_cnt_q <= bubble_cnt_d;
        end
    end

    assign pipe.ex_ALUOp     = ex_aluop_q;
    assign pipe.ex_valid     = ex_valid_q;
    assign pipe.ex_rd        = ex_rd_q;
    assign pipe.mem_MEMSig   = mem_mem_q;
    assign pipe.mem_valid    = mem_valid_q;
    assign pipe.mem_rd       = mem_rd_q;
    assign pipe.wb_regwrite  = wb_wb_q & wb_valid_q & (wb_rd_q != '0);
    assign pipe.wb_valid     = wb_valid_q;
    assign pipe.wb_rd        = wb_rd_q;
    assign pipe.bubble_count = bubble_cnt_q;

endmodule

// File: tb/tb_control_pipe.sv
// Self-checking bench for control_pipe: directed scenarios followed by random
// traffic, compared against an instruction-level model of the three stages.
// A second instance with a 2-bit counter exercises saturation.
module tb_control_pipe;

    localparam int RD_W = 5;

    logic clk;
    logic rst_n;

    control_pipe_if #(.RD_W(RD_W), .CNT_W(16)) busBig ();
    control_pipe_if #(.RD_W(RD_W), .CNT_W(2))  busSmall ();

    control_pipe #(.RD_W(RD_W), .CNT_W(16)) dutBig (
        .clk  (clk),
        .rst_n(rst_n),
        .pipe (busBig.slave)
    );

    control_pipe #(.RD_W(RD_W), .CNT_W(2)) dutSmall (
        .clk  (clk),
        .rst_n(rst_n),
        .pipe (busSmall.slave)
    );

    // 10 ns clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // An instruction as it sits in a stage of the model
    typedef struct {
        int  aluop;
        bit  wb;
        bit  mem;
        bit  valid;
        int  rd;
    } instr_t;

    instr_t exM, memM, wbM;
    int     cntBig;
    int     cntSmall;
    int     vectors;
    int     miscompares;

    function automatic instr_t bubble();
        instr_t b;
        b.aluop = 0; b.wb = 0; b.mem = 0; b.valid = 0; b.rd = 0;
        return b;
    endfunction

    function automatic int satAdd(int value, int inc, int maxVal);
        return (value + inc > maxVal) ? maxVal : value + inc;
    endfunction

    task automatic modelReset();
        exM = bubble(); memM = bubble(); wbM = bubble();
        cntBig = 0; cntSmall = 0;
    endtask

    // One rising edge of the pipeline, in instruction terms
    task automatic modelEdge();
        instr_t idI;
        if (!rst_n) begin
            modelReset();
        end else if (!busBig.mem_wait) begin
            idI = bubble();
            if (busBig.id_valid) begin
                idI.aluop = int'(busBig.controlSig[3:2]);
                idI.wb    = busBig.controlSig[1];
                idI.mem   = busBig.controlSig[0];
                idI.valid = 1;
                idI.rd    = int'(busBig.id_rd);
            end
            if (busBig.flush) begin
                wbM  = memM;
                memM = bubble();
                exM  = bubble();
                cntBig   = satAdd(cntBig, 2, 65535);
                cntSmall = satAdd(cntSmall, 2, 3);
            end else if (busBig.stall) begin
                wbM  = memM;
                memM = exM;
                exM  = bubble();
                cntBig   = satAdd(cntBig, 1, 65535);
                cntSmall = satAdd(cntSmall, 1, 3);
            end else begin
                wbM  = memM;
                memM = exM;
                exM  = idI;
            end
        end
    endtask

    task automatic checkValue(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
        vectors++;
        assert (observed === expected)
        else begin
            miscompares++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic checkOutput();
        checkValue("ex_ALUOp",    32'(busBig.ex_ALUOp),    32'(exM.aluop));
        checkValue("ex_valid",    32'(busBig.ex_valid),    32'(exM.valid));
        checkValue("ex_rd",       32'(busBig.ex_rd),       32'(exM.rd));
        checkValue("mem_MEMSig",  32'(busBig.mem_MEMSig),  32'(memM.mem));
        checkValue("mem_valid",   32'(busBig.mem_valid),   32'(memM.valid));
        checkValue("mem_rd",      32'(busBig.mem_rd),      32'(memM.rd));
        checkValue("wb_regwrite", 32'(busBig.wb_regwrite),
                   32'(wbM.wb && wbM.valid && wbM.rd != 0));
        checkValue("wb_valid",    32'(busBig.wb_valid),    32'(wbM.valid));
        checkValue("wb_rd",       32'(busBig.wb_rd),       32'(wbM.rd));
        checkValue("bubble_count",       32'(busBig.bubble_count),   32'(cntBig));
        checkValue("small_bubble_count", 32'(busSmall.bubble_count), 32'(cntSmall));
        checkValue("small_wb_rd",        32'(busSmall.wb_rd),        32'(wbM.rd));
    endtask

    // Drives identical inputs onto both instances
    task automatic applyStimulus(input logic [3:0] ctrl, input logic valid,
                                 input logic [RD_W-1:0] rd, input logic st,
                                 input logic fl, input logic mw);
        busBig.controlSig   = ctrl;  busSmall.controlSig = ctrl;
        busBig.id_valid     = valid; busSmall.id_valid   = valid;
        busBig.id_rd        = rd;    busSmall.id_rd      = rd;
        busBig.stall        = st;    busSmall.stall      = st;
        busBig.flush        = fl;    busSmall.flush      = fl;
        busBig.mem_wait     = mw;    busSmall.mem_wait   = mw;
    endtask

    task automatic applyRandom(input int stallPct, input int flushPct, input int waitPct);
        applyStimulus(4'($urandom), 1'($urandom_range(0, 3) != 0), RD_W'($urandom),
                      1'($urandom_range(0, 99) < stallPct),
                      1'($urandom_range(0, 99) < flushPct),
                      1'($urandom_range(0, 99) < waitPct));
    endtask

    // Rising edge, model update, then check on the falling edge
    task automatic tick();
        @(posedge clk);
        modelEdge();
        @(negedge clk);
        checkOutput();
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        rst_n = 1'b0;
        modelReset();
        applyStimulus(4'h0, 1'b0, '0, 1'b0, 1'b0, 1'b0);

        // Reset held with random inputs: everything stays zero
        for (int i = 0; i < 3; i++) begin
            applyRandom(30, 30, 30);
            tick();
        end

        // Release and push 1011 / rd 8 down the pipe
        rst_n = 1'b1;
        applyStimulus(4'b1011, 1'b1, 5'd8, 1'b0, 1'b0, 1'b0);
        tick();
        checkValue("lat1_ex_ALUOp", 32'(busBig.ex_ALUOp), 32'd2);
        applyStimulus(4'b0000, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
        tick();
        checkValue("lat2_mem_MEMSig", 32'(busBig.mem_MEMSig), 32'd1);
        tick();
        checkValue("lat3_wb_regwrite", 32'(busBig.wb_regwrite), 32'd1);
        checkValue("lat3_wb_rd", 32'(busBig.wb_rd), 32'd8);

        // Writes to register 0 stay valid but are not committed
        applyStimulus(4'b0010, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0);
        tick();
        applyStimulus(4'b0000, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
        tick();
        tick();
        checkValue("r0_wb_valid", 32'(busBig.wb_valid), 32'd1);
        checkValue("r0_wb_regwrite", 32'(busBig.wb_regwrite), 32'd0);

        // Fill the pipe, then stall with A in ID
        applyStimulus(4'b0110, 1'b1, 5'd3, 1'b0, 1'b0, 1'b0);
        tick();
        applyStimulus(4'b1111, 1'b1, 5'd4, 1'b0, 1'b0, 1'b0);
        tick();
        applyStimulus(4'b1011, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0);
        tick();
        checkValue("stall_ex_valid", 32'(busBig.ex_valid), 32'd0);
        checkValue("stall_mem_rd", 32'(busBig.mem_rd), 32'd4);
        checkValue("stall_count", 32'(busBig.bubble_count), 32'd1);

        // Flush with A in EX and B in ID, then flush and stall together
        applyStimulus(4'b1011, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0);
        tick();
        applyStimulus(4'b0111, 1'b1, 5'd6, 1'b0, 1'b1, 1'b0);
        tick();
        checkValue("flush_mem_valid", 32'(busBig.mem_valid), 32'd0);
        checkValue("flush_count", 32'(busBig.bubble_count), 32'd3);
        applyStimulus(4'b0111, 1'b1, 5'd6, 1'b1, 1'b1, 1'b0);
        tick();
        checkValue("flush_stall_count", 32'(busBig.bubble_count), 32'd5);

        // Memory wait for three cycles with a flush pulse in the middle
        applyStimulus(4'b1110, 1'b1, 5'd9, 1'b0, 1'b0, 1'b0);
        tick();
        applyStimulus(4'b1110, 1'b1, 5'd10, 1'b0, 1'b0, 1'b1);
        tick();
        applyStimulus(4'b1110, 1'b1, 5'd10, 1'b0, 1'b1, 1'b1);
        tick();
        applyStimulus(4'b1110, 1'b1, 5'd10, 1'b0, 1'b0, 1'b1);
        tick();
        checkValue("wait_count", 32'(busBig.bubble_count), 32'd5);
        applyStimulus(4'b1110, 1'b1, 5'd10, 1'b0, 1'b0, 1'b0);
        tick();

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            applyRandom(15, 10, 15);
            tick();
        end

        // Asynchronous reset mid-cycle
        applyRandom(0, 0, 0);
        @(posedge clk);
        modelEdge();
        #2;
        rst_n = 1'b0;
        modelReset();
        #1;
        checkOutput();
        @(negedge clk);
        rst_n = 1'b1;

        // Saturation of the 2-bit counter: 1, 2, 3, then a flush stays at 3
        applyStimulus(4'b0000, 1'b1, 5'd1, 1'b1, 1'b0, 1'b0);
        tick();
        tick();
        tick();
        checkValue("sat_stall", 32'(busSmall.bubble_count), 32'd3);
        applyStimulus(4'b0000, 1'b1, 5'd1, 1'b0, 1'b1, 1'b0);
        tick();
        checkValue("sat_flush", 32'(busSmall.bubble_count), 32'd3);
        checkValue("sat_big_count", 32'(busBig.bubble_count), 32'd5);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
